// File: rtl/opb_master_pkg.sv
// opb_master_pkg: shared states, status codes and defaults for the single-beat OPB master
package opb_master_pkg;
  typedef enum logic [2:0] {IDLE, REQ, XFER, BACKOFF, DONE} state_t;
  typedef enum logic [1:0] {ST_OK = 2'b00, ST_ERR = 2'b01, ST_TOUT = 2'b10, ST_RETRY = 2'b11} status_t;
  localparam int DEF_TIMEOUT   = 16;
  localparam int DEF_MAX_RETRY = 3;
endpackage

// File: rtl/opb_master_tout_cnt.sv
// opb_master_tout_cnt: clear/enable/hold counter; tc flags the cycle whose increment reaches C_TIMEOUT
module opb_master_tout_cnt import opb_master_pkg::*; #(
  parameter int C_TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int W = $clog2(C_TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(C_TIMEOUT - 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  assign tc = en && cnt == LAST;
endmodule

// File: rtl/opb_single_master.sv
// opb_single_master: single-beat OPB initiator taking one read/write command at a time
// and returning a one-cycle response with read data and completion status.
module opb_single_master import opb_master_pkg::*; #(
  parameter int C_OPB_AWIDTH = 32,
  parameter int C_OPB_DWIDTH = 32,
  parameter int C_TIMEOUT    = DEF_TIMEOUT,
  parameter int C_MAX_RETRY  = DEF_MAX_RETRY
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_rnw,
  input  logic [C_OPB_AWIDTH-1:0]   cmd_addr,
  input  logic [C_OPB_DWIDTH/8-1:0] cmd_be,
  input  logic [C_OPB_DWIDTH-1:0]   cmd_wdata,
  output logic                      rsp_valid,
  output logic [C_OPB_DWIDTH-1:0]   rsp_rdata,
  output logic [1:0]                rsp_status,
  output logic                      M_request,
  output logic                      M_select,
  output logic                      M_RNW,
  output logic                      M_seqAddr,
  output logic                      M_busLock,
  output logic [0:C_OPB_AWIDTH-1]   M_ABus,
  output logic [0:C_OPB_DWIDTH/8-1] M_BE,
  output logic [0:C_OPB_DWIDTH-1]   M_DBus,
  input  logic                      OPB_MGrant,
  input  logic                      OPB_xferAck,
  input  logic                      OPB_errAck,
  input  logic                      OPB_retry,
  input  logic                      OPB_toutSup,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus
);
  localparam int RW = $clog2(C_MAX_RETRY + 2);
  localparam logic [RW-1:0] RMAX = RW'(C_MAX_RETRY);
  state_t state, state_nxt;
  status_t st_nxt;
  logic [RW-1:0] retry_q, retry_nxt;
  logic rnw_q, accept, tout, to_xfer;
  logic [C_OPB_AWIDTH-1:0] addr_q;
  logic [C_OPB_DWIDTH/8-1:0] be_q;
  logic [C_OPB_DWIDTH-1:0] wdata_q;
  assign M_seqAddr = 1'b0;
  assign M_busLock = 1'b0;
  assign accept = state == IDLE && cmd_valid;
  assign to_xfer = state_nxt == XFER;
  opb_master_tout_cnt #(.C_TIMEOUT(C_TIMEOUT)) u_tout (
    .clk  (OPB_Clk),
    .rst_n(OPB_Rst),
    .clr  (state != XFER),
    .en   (state == XFER && !OPB_toutSup),
    .tc   (tout)
  );
  always_ff @(posedge OPB_Clk or negedge OPB_Rst)
    if (!OPB_Rst) state <= IDLE;
    else state <= state_nxt;
  // Exit priority in XFER: ack, then errAck, then retry, then timeout
  always_comb begin
    state_nxt = state;
    st_nxt = ST_OK;
    retry_nxt = accept ? '0 : retry_q;
    case (state)
      IDLE:    state_nxt = cmd_valid ? REQ : IDLE;
      REQ:     state_nxt = OPB_MGrant ? XFER : REQ;
      XFER:
        if (OPB_xferAck) begin
          state_nxt = DONE;
          st_nxt = OPB_errAck ? ST_ERR : ST_OK;
        end else if (OPB_errAck) begin
          state_nxt = DONE;
          st_nxt = ST_ERR;
        end else if (OPB_retry) begin
          retry_nxt = retry_q + 1'b1;
          state_nxt = retry_nxt > RMAX ? DONE : BACKOFF;
          st_nxt = ST_RETRY;
        end else if (tout) begin
          state_nxt = DONE;
          st_nxt = ST_TOUT;
        end
      BACKOFF: state_nxt = REQ;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // Outputs are decoded from the next state so every one of them comes straight off a flop
  always_ff @(posedge OPB_Clk or negedge OPB_Rst)
    if (!OPB_Rst) begin
      rnw_q      <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      retry_q    <= '0;
      cmd_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_status <= ST_OK;
      M_request  <= 1'b0;
      M_select   <= 1'b0;
      M_RNW      <= 1'b0;
      M_ABus     <= '0;
      M_BE       <= '0;
      M_DBus     <= '0;
    end else begin
      if (accept) begin
        rnw_q   <= cmd_rnw;
        addr_q  <= cmd_addr;
        be_q    <= cmd_be;
        wdata_q <= cmd_wdata;
      end
      retry_q    <= retry_nxt;
      cmd_ready  <= state_nxt == IDLE;
      rsp_valid  <= state_nxt == DONE;
      rsp_status <= state_nxt == DONE ? st_nxt : ST_OK;
      rsp_rdata  <= state_nxt == DONE && rnw_q && st_nxt == ST_OK ? OPB_DBus : '0;
      M_request  <= state_nxt == REQ;
      M_select   <= to_xfer;
      M_RNW      <= to_xfer && rnw_q;
      M_ABus     <= to_xfer ? addr_q : '0;
      M_BE       <= to_xfer ? be_q : '0;
      M_DBus     <= to_xfer && !rnw_q ? wdata_q : '0;
    end
endmodule

// File: tb/tb_opb_single_master.sv
// tb_opb_single_master: directed commands against a scripted OPB slave, scoreboarded responses
module tb_opb_single_master;
  import opb_master_pkg::*;
  logic OPB_Clk = 0, OPB_Rst = 1, cmd_valid = 0, cmd_rnw = 0;
  logic [31:0] cmd_addr = 0, cmd_wdata = 0;
  logic [3:0] cmd_be = 0;
  logic cmd_ready, rsp_valid, M_request, M_select, M_RNW, M_seqAddr, M_busLock;
  logic [31:0] rsp_rdata;
  logic [1:0] rsp_status;
  logic [0:31] M_ABus, M_DBus;
  logic [0:3] M_BE;
  logic OPB_MGrant = 1, OPB_xferAck = 0, OPB_errAck = 0, OPB_retry = 0, OPB_toutSup = 0;
  logic [0:31] OPB_DBus = 0;

  typedef struct {logic [1:0] st; logic [31:0] rd; int cyc;} exp_t;
  exp_t q[$];
  int pass_cnt = 0, total = 0, cyc = 0, sel_cnt = 0, req_rise = 0, att = 0, xc = 0;
  int ack_at = 0, err_at = 0, retry_n = 0, tsup_n = 0;
  logic [31:0] rd_val = 0, exp_addr = 0, exp_dbus = 0;
  logic [3:0] exp_be = 0;
  logic exp_rnw = 0, req_prev = 0, rsp_prev = 0;

  opb_single_master dut (
    .OPB_Clk(OPB_Clk), .OPB_Rst(OPB_Rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rnw(cmd_rnw), .cmd_addr(cmd_addr), .cmd_be(cmd_be), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
    .M_request(M_request), .M_select(M_select), .M_RNW(M_RNW), .M_seqAddr(M_seqAddr),
    .M_busLock(M_busLock), .M_ABus(M_ABus), .M_BE(M_BE), .M_DBus(M_DBus),
    .OPB_MGrant(OPB_MGrant), .OPB_xferAck(OPB_xferAck), .OPB_errAck(OPB_errAck),
    .OPB_retry(OPB_retry), .OPB_toutSup(OPB_toutSup), .OPB_DBus(OPB_DBus)
  );

  always #5 OPB_Clk = ~OPB_Clk;
  always @(posedge OPB_Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Scripted slave: retries the first retry_n attempts, then holds toutSup, acks and errAcks
  // at the given XFER cycle of the attempt (0 = never)
  initial forever begin
    @(posedge OPB_Clk);
    #1;
    if (!M_select) begin
      xc = 0;
      {OPB_xferAck, OPB_errAck, OPB_retry, OPB_toutSup} = 4'b0;
      OPB_DBus = 0;
    end else begin
      xc++;
      OPB_DBus = M_RNW ? rd_val : 32'h0;
      if (att < retry_n) begin
        OPB_retry = 1;
        att++;
      end else begin
        OPB_retry = 0;
        OPB_toutSup = xc <= tsup_n;
        OPB_xferAck = ack_at != 0 && xc == ack_at;
        OPB_errAck = err_at != 0 && xc == err_at;
      end
    end
  end

  always @(negedge OPB_Clk) if (OPB_Rst) begin
    if (M_select) begin
      chk("abus", M_ABus, exp_addr);
      chk("be", M_BE, exp_be);
      chk("dbus", M_DBus, exp_dbus);
      chk("rnw", M_RNW, exp_rnw);
      sel_cnt++;
    end else begin
      chk("idle_abus_rnw", {M_ABus, M_RNW}, 0);
      chk("idle_be_dbus", {M_BE, M_DBus}, 0);
    end
    chk("tied_low", {M_seqAddr, M_busLock}, 0);
    if (M_request && !req_prev) req_rise++;
    req_prev = M_request;
  end

  always @(negedge OPB_Clk) if (OPB_Rst) begin
    exp_t e;
    if (rsp_valid) begin
      chk("rsp_pulse", rsp_prev, 0);
      chk("ready_in_done", cmd_ready, 0);
      if (q.size() == 0) chk("unexpected_rsp", rsp_valid, 0);
      else begin
        e = q.pop_front();
        chk("status", rsp_status, e.st);
        chk("rdata", rsp_rdata, e.rd);
        if (e.cyc != 0) chk("latency", cyc, e.cyc);
      end
    end
    rsp_prev = rsp_valid;
  end

  task automatic cfg(input int a, input int e, input int r, input int t, input logic [31:0] rv);
    ack_at = a; err_at = e; retry_n = r; tsup_n = t; rd_val = rv;
    att = 0; sel_cnt = 0; req_rise = 0;
  endtask

  // lat: spec cycle number of rsp_valid after the accept edge (0 = unchecked, <0 = no response)
  task automatic issue(input logic rnw, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, input logic [1:0] st, input logic [31:0] rd, input int lat);
    int n = 0;
    @(negedge OPB_Clk);
    while (!cmd_ready && n < 100) begin
      @(negedge OPB_Clk);
      n++;
    end
    chk("cmd_ready", cmd_ready, 1);
    exp_addr = addr; exp_be = be; exp_rnw = rnw; exp_dbus = rnw ? 32'h0 : wd;
    cmd_rnw = rnw; cmd_addr = addr; cmd_be = be; cmd_wdata = wd; cmd_valid = 1;
    @(posedge OPB_Clk);
    #1;
    cmd_valid = 0;
    chk("ready_drop", cmd_ready, 0);
    if (lat >= 0) q.push_back('{st, rd, lat > 0 ? cyc + lat - 1 : 0});
  endtask

  task automatic wait_done();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge OPB_Clk);
      n++;
    end
    chk("rsp_outstanding", q.size(), 0);
    q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    #1 OPB_Rst = 0;
    repeat (2) @(negedge OPB_Clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_ctrl", {rsp_valid, rsp_status, M_request, M_select, M_RNW, M_seqAddr, M_busLock}, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_abus", M_ABus, 0);
    chk("rst_be_dbus", {M_BE, M_DBus}, 0);
    OPB_Rst = 1;
    cfg(1, 0, 0, 0, 0);
    issue(0, 32'h01000004, 4'hF, 32'h12345678, ST_OK, 0, 3);
    wait_done();
    cfg(1, 0, 0, 0, 32'hDEADBEEF);
    issue(1, 32'h01000000, 4'hF, 0, ST_OK, 32'hDEADBEEF, 3);
    wait_done();
    cfg(0, 0, 0, 0, 32'h13579BDF);
    issue(1, 32'h01000010, 4'hF, 0, ST_TOUT, 0, 18);
    wait_done();
    chk("tout_sel_cycles", sel_cnt, 16);
    cfg(45, 0, 0, 40, 0);
    issue(0, 32'h01000020, 4'hF, 32'hA0B1C2D3, ST_OK, 0, 47);
    wait_done();
    chk("toutsup_sel_cycles", sel_cnt, 45);
    cfg(0, 0, 4, 0, 0);
    issue(0, 32'h01000030, 4'hF, 32'h0F0F0F0F, ST_RETRY, 0, 12);
    wait_done();
    chk("retry_req_count", req_rise, 4);
    chk("retry_sel_count", sel_cnt, 4);
    cfg(2, 2, 0, 0, 32'hA5A5A5A5);
    issue(1, 32'h01000040, 4'hF, 0, ST_ERR, 0, 4);
    wait_done();
    cfg(0, 3, 0, 0, 0);
    issue(0, 32'h01000044, 4'hC, 32'h87654321, ST_ERR, 0, 5);
    wait_done();
    cfg(1, 0, 2, 0, 32'h0BADF00D);
    issue(1, 32'h01000048, 4'h3, 0, ST_OK, 32'h0BADF00D, 9);
    wait_done();
    chk("retry_ok_req_count", req_rise, 3);
    cfg(1, 0, 0, 0, 0);
    OPB_MGrant = 0;
    issue(0, 32'h00000ABC, 4'h3, 32'hCAFEF00D, ST_OK, 0, 6);
    repeat (3) @(posedge OPB_Clk);
    #1;
    chk("gnt_wait_req", M_request, 1);
    chk("gnt_wait_sel", M_select, 0);
    OPB_MGrant = 1;
    wait_done();
    cfg(0, 0, 0, 1000, 32'h11111111);
    issue(1, 32'h02000000, 4'hF, 0, ST_OK, 0, -1);
    n = 0;
    while (!M_select && n < 20) begin
      @(negedge OPB_Clk);
      n++;
    end
    chk("rst_test_sel", M_select, 1);
    @(posedge OPB_Clk);
    #3 OPB_Rst = 0;
    #1;
    chk("async_ctrl", {M_request, M_select, M_RNW, rsp_valid}, 0);
    chk("async_abus", M_ABus, 0);
    chk("async_ready", cmd_ready, 1);
    repeat (2) @(negedge OPB_Clk);
    OPB_Rst = 1;
    repeat (3) @(negedge OPB_Clk);
    chk("post_rst_ready", cmd_ready, 1);
    chk("post_rst_queue", q.size(), 0);
    cfg(1, 0, 0, 0, 0);
    issue(0, 32'h01000008, 4'hF, 32'h55AA55AA, ST_OK, 0, 3);
    wait_done();
    repeat (2) @(negedge OPB_Clk);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
